// File: rtl/match_logger.sv
// match_logger: logs lengths of match runs from a sequence detector into a FWFT FIFO
//   clk, rst_n        : clock, async active-low reset
//   ans               : match level from the detector
//   clr               : sync clear of match_cnt and overflow
//   pop               : consumer removes head entry
//   rd_data/rd_valid  : head entry (0 when empty) / FIFO not empty
//   full              : FIFO holds DEPTH entries
//   match_cnt         : runs started, saturating at 255
//   overflow          : sticky, a finished run was dropped on a full FIFO
module match_logger #(
    parameter int LEN_W = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ans,
    input  logic             clr,
    input  logic             pop,
    output logic [LEN_W-1:0] rd_data,
    output logic             rd_valid,
    output logic             full,
    output logic [7:0]       match_cnt,
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nxt;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] occ;
    logic push, do_push, do_pop;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    // a falling ans while in RUN ends the run and pushes it; a pop on a full
    // FIFO in the same edge frees the slot, so the push is kept
    always_comb begin
        state_nxt = ans ? RUN : IDLE;
        push = state == RUN && !ans;
        do_pop = pop && rd_valid;
        do_push = push && (!full || do_pop);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            len <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ <= '0;
            match_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (ans) len <= state == IDLE ? LEN_W'(1) : (len == '1 ? len : len + 1'b1);
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            occ <= do_push && !do_pop ? occ + 1'b1 : !do_push && do_pop ? occ - 1'b1 : occ;
            match_cnt <= clr ? 8'd0 : state == IDLE && ans && match_cnt != 8'hFF ? match_cnt + 8'd1 : match_cnt;
            overflow <= clr ? 1'b0 : overflow || (push && !do_push);
        end
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= len;
    assign rd_valid = occ != '0;
    assign full = occ == DEPTH_CNT;
    assign rd_data = rd_valid ? mem[rd_ptr] : '0;
endmodule

// File: doc/match_logger.md
MATCH_LOGGER -- requirements
Module: match_logger

Interface
REQ-001 Parameter LEN_W, default 4: width of each run-length entry; saturating maximum is 2^LEN_W-1.
REQ-002 Parameter DEPTH, default 4: FIFO entry count; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 ans  input  1  match level from the upstream sequence detector; high while the detector sits in its match state.
REQ-006 clr  input  1  synchronous clear of match_cnt and overflow.
REQ-007 pop  input  1  consumer removes the head FIFO entry.
REQ-008 rd_data  output  LEN_W  head FIFO entry, first-word-fall-through.
REQ-009 rd_valid  output  1  FIFO not empty.
REQ-010 full  output  1  FIFO holds DEPTH entries.
REQ-011 match_cnt  output  8  number of match runs started, saturating at 255.
REQ-012 overflow  output  1  sticky; a completed run was dropped because the FIFO was full.

Function
REQ-013 FSM states SHALL be IDLE and RUN only; the value of ans sampled at each rising clk edge drives the transitions.
REQ-014 IDLE with ans=1 -> RUN; len<=1; match_cnt increments by 1, holding at 255.
REQ-015 IDLE with ans=0 -> IDLE; len and match_cnt unchanged.
REQ-016 RUN with ans=1 -> RUN; len<=len+1, holding at 2^LEN_W-1 with no wrap.
REQ-017 RUN with ans=0 -> IDLE; push current len into the FIFO in that same edge. The sample that ends the run is not counted in len.
REQ-018 A push takes effect on the edge that leaves RUN; the entry is visible on rd_data/rd_valid in the following cycle.
REQ-019 rd_data SHALL equal the oldest stored entry whenever rd_valid=1, and SHALL be 0 whenever rd_valid=0.
REQ-020 pop with rd_valid=1 removes the head at the edge; pop with rd_valid=0 is ignored with no state change.
REQ-021 Push and pop in the same edge, FIFO non-empty: both occur; occupancy unchanged, including when full.
REQ-022 Push with FIFO full and no pop: entry dropped, FIFO contents unchanged, overflow<=1.
REQ-023 Push and pop in the same edge, FIFO empty: the pop is ignored and the push is stored.
REQ-024 Pointers are log2(DEPTH) bits wrapping modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits; full = (occupancy==DEPTH).
REQ-025 clr=1: match_cnt<=0 and overflow<=0 at the edge, overriding any increment or overflow set in that edge.
REQ-026 clr does not affect the FSM state, len, or FIFO contents.
REQ-027 overflow stays at 1 until clr or reset.
REQ-028 Outputs are registered or derived only from registered state; there is no combinational path from ans, pop or clr to any output.

Reset
REQ-029 rst_n=0 SHALL immediately, without a clock, force state=IDLE, len=0, FIFO empty (pointers and occupancy 0), match_cnt=0 and overflow=0.
REQ-030 While rst_n=0 the outputs SHALL read rd_valid=0, rd_data=0, full=0, match_cnt=0, overflow=0.
REQ-031 A reset asserted during RUN discards the in-progress run; nothing is pushed.
REQ-032 After rst_n deasserts, the first capture is on the next rising clk edge; ans already high at that edge starts a new run (match_cnt=1).

Verification
REQ-033 Scenario: ans high 3 cycles, then low -> rd_valid=1, rd_data=3, match_cnt=1; pop once -> rd_valid=0, rd_data=0.
REQ-034 Scenario: ans high 20 cycles, then low -> rd_data=15 (saturated), match_cnt=1.
REQ-035 Scenario: five 1-cycle pulses separated by low cycles, no pops -> full=1 after the 4th; 5th pulse sets overflow=1; FIFO holds four entries of 1; match_cnt=5.
REQ-036 Scenario: FIFO full, then a run ends in the same cycle as pop=1 -> overflow stays 0; full stays 1; the new entry reads out last in FIFO order.
REQ-037 Scenario: 256 separate runs, then a clr pulse coincident with a new run start -> match_cnt holds 255 before clr and reads 0 after clr; the FSM enters RUN and the run is still logged.
REQ-038 Scenario: rst_n pulsed low mid-run with two entries queued -> asynchronously rd_valid=0, match_cnt=0; after release, the first ans=1 edge gives match_cnt=1.
